// File: rtl/moving_average_pkg.sv
// Shared types and the shift-and-round helper for the windowed moving average.
// Widths are the block defaults; the function works on a wide signed container.
package moving_average_pkg;

    localparam int SAMPLE_WD = 16;
    localparam int LOG2_LEN_DEF = 3;
    localparam int SUM_WD = SAMPLE_WD + LOG2_LEN_DEF;
    localparam int CALC_WD = 64;

    typedef logic signed [SAMPLE_WD-1:0] sample_t;
    typedef logic signed [SUM_WD-1:0] sum_t;
    typedef logic signed [CALC_WD-1:0] calc_t;

    // Divide by 2**log2_len, either flooring or rounding half up.
    function automatic calc_t avg_shift(input calc_t sum, input int unsigned log2_len,
                                        input bit round_en);
        calc_t bias;
        bias = '0;
        if (round_en && (log2_len > 0)) begin
            bias = calc_t'(1) <<< (log2_len - 1);
        end
        return (sum + bias) >>> log2_len;
    endfunction

endpackage

// File: rtl/ma_history_buf.sv
// Circular sample history. The read port prefetches the entry at rd_ptr so the
// oldest sample is ready from a register when the next sample arrives.
module ma_history_buf #(
    parameter int DATA_WD = 16,
    parameter int DEPTH   = 8,
    parameter int PTR_WD  = 3
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [PTR_WD-1:0]         wr_ptr,
    input  logic signed [DATA_WD-1:0] wr_data,
    input  logic [PTR_WD-1:0]         rd_ptr,
    output logic signed [DATA_WD-1:0] old_data
);

    logic signed [DATA_WD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
        // A one-entry window reads back the sample being written this edge.
        if (wr_en && (rd_ptr == wr_ptr)) begin
            old_data <= wr_data;
        end else begin
            old_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/moving_average_win.sv
// Moving average over the last 2**LOG2_LEN samples, latency one cycle.
// Missing history before the window fills is treated as zeros.
module moving_average_win
    import moving_average_pkg::*;
#(
    parameter int DATA_WD  = 16,
    parameter int LOG2_LEN = 3,
    parameter int ROUND    = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rstb,
    input  logic                      i_valid,
    input  logic signed [DATA_WD-1:0] i_data,
    input  logic                      i_flush,
    output logic                      o_valid,
    output logic signed [DATA_WD-1:0] o_data,
    output logic                      o_full
);

    localparam int N = 1 << LOG2_LEN;
    localparam int S_WD = DATA_WD + LOG2_LEN;
    localparam int CNT_WD = LOG2_LEN + 1;
    localparam int PTR_WD = (LOG2_LEN > 0) ? LOG2_LEN : 1;
    localparam logic [CNT_WD-1:0] FILL_MAX = CNT_WD'(N);
    localparam logic [PTR_WD-1:0] PTR_MAX = PTR_WD'(N - 1);

    logic signed [S_WD-1:0]    sum_reg, sum_next, base_sum;
    logic [CNT_WD-1:0]         fill_reg, fill_next, base_fill;
    logic [PTR_WD-1:0]         ptr_reg, ptr_next, base_ptr;
    logic signed [DATA_WD-1:0] data_reg, data_next;
    logic                      valid_reg, full_reg;
    logic signed [DATA_WD-1:0] old_data, oldest;
    calc_t                     avg;

    ma_history_buf #(
        .DATA_WD(DATA_WD),
        .DEPTH  (N),
        .PTR_WD (PTR_WD)
    ) u_hist (
        .clk     (i_clk),
        .wr_en   (i_valid),
        .wr_ptr  (base_ptr),
        .wr_data (i_data),
        .rd_ptr  (ptr_next),
        .old_data(old_data)
    );

    always_comb begin
        // Flush takes effect before a coincident sample.
        base_sum  = i_flush ? '0 : sum_reg;
        base_fill = i_flush ? '0 : fill_reg;
        base_ptr  = i_flush ? '0 : ptr_reg;
        oldest    = (base_fill == FILL_MAX) ? old_data : '0;
        sum_next  = base_sum;
        fill_next = base_fill;
        ptr_next  = base_ptr;
        data_next = data_reg;
        avg       = '0;
        if (i_valid) begin
            sum_next = base_sum + S_WD'(i_data) - S_WD'(oldest);
            if (base_fill != FILL_MAX) begin
                fill_next = base_fill + 1'b1;
            end
            ptr_next  = (base_ptr == PTR_MAX) ? '0 : base_ptr + 1'b1;
            avg       = avg_shift(calc_t'(sum_next), LOG2_LEN, ROUND != 0);
            data_next = DATA_WD'(avg);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            sum_reg   <= '0;
            fill_reg  <= '0;
            ptr_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            full_reg  <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            fill_reg  <= fill_next;
            ptr_reg   <= ptr_next;
            data_reg  <= data_next;
            valid_reg <= i_valid;
            full_reg  <= (fill_next == FILL_MAX);
        end
    end

    assign o_valid = valid_reg;
    assign o_data  = data_reg;
    assign o_full  = full_reg;

endmodule

// File: tb/tb_moving_average_win.sv
// Directed bench for moving_average_win with a 4-sample window; a flooring
// and a rounding instance see identical stimulus.
module tb_moving_average_win;

    logic               i_clk;
    logic               i_rstb;
    logic               i_valid;
    logic signed [15:0] i_data;
    logic               i_flush;
    logic               o_valid, o_full, r_valid, r_full;
    logic signed [15:0] o_data, r_data;

    int n_checks = 0;
    int n_fail   = 0;

    moving_average_win #(.DATA_WD(16), .LOG2_LEN(2), .ROUND(0)) dut (
        .i_clk  (i_clk),
        .i_rstb (i_rstb),
        .i_valid(i_valid),
        .i_data (i_data),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_full (o_full)
    );

    moving_average_win #(.DATA_WD(16), .LOG2_LEN(2), .ROUND(1)) dut_r (
        .i_clk  (i_clk),
        .i_rstb (i_rstb),
        .i_valid(i_valid),
        .i_data (i_data),
        .i_flush(i_flush),
        .o_valid(r_valid),
        .o_data (r_data),
        .o_full (r_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and return just after the capturing edge.
    task automatic drive(input logic v, input int d, input logic f);
        @(negedge i_clk);
        i_valid = v;
        i_data  = 16'(d);
        i_flush = f;
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int valid, input int data, input int full);
        check({tag, ".valid"}, int'(o_valid), valid);
        check({tag, ".data"}, int'(o_data), data);
        check({tag, ".full"}, int'(o_full), full);
        $display("txn %-10s valid=%0d data=%0d full=%0d", tag, o_valid, o_data, o_full);
    endtask

    int ramp_in [5]  = '{4, 8, 12, 16, 20};
    int ramp_out [5] = '{1, 3, 6, 10, 14};
    int ramp_full [5] = '{0, 0, 0, 1, 1};
    int fill_out [4] = '{10, 20, 30, 40};
    int rnd_out [5]  = '{0, 0, -1, -1, -1};

    initial begin
        i_rstb  = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_flush = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        expect_out("reset", 0, 0, 0);
        @(negedge i_clk);
        i_rstb = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ramp_in[i], 1'b0);
            expect_out($sformatf("ramp%0d", i), 1, ramp_out[i], ramp_full[i]);
            check($sformatf("ramp%0d.rnd", i), int'(r_data), ramp_out[i]);
        end
        drive(1'b0, 0, 1'b0);
        expect_out("idle", 0, 14, 1);

        // Flush alone holds data, drops full.
        drive(1'b0, 0, 1'b1);
        expect_out("flush", 0, 14, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 40, 1'b0);
            expect_out($sformatf("f40_%0d", i), 1, fill_out[i], (i == 3) ? 1 : 0);
        end
        drive(1'b1, 100, 1'b1);
        expect_out("flush_val", 1, 25, 0);
        check("flush_val.rnd", int'(r_data), 25);

        // Rounding of a constant -1 stream.
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, -1, 1'b0);
            expect_out($sformatf("neg%0d", i), 1, -1, (i >= 3) ? 1 : 0);
            check($sformatf("neg%0d.rnd", i), int'(r_data), rnd_out[i]);
        end

        // Extremes.
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 32767, 1'b0);
        expect_out("max", 1, 32767, 1);
        check("max.rnd", int'(r_data), 32767);
        drive(1'b0, 0, 1'b1);
        drive(1'b1, -32768, 1'b0);
        expect_out("min_first", 1, -8192, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, -32768, 1'b0);
        expect_out("min", 1, -32768, 1);
        check("min.rnd", int'(r_data), -32768);

        // Gaps between samples.
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 8, 1'b0);
        expect_out("gap_a", 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b0);
            expect_out($sformatf("gap_idle%0d", i), 0, 2, 0);
        end
        drive(1'b1, 8, 1'b0);
        expect_out("gap_b", 1, 4, 0);

        // Asynchronous reset mid-window.
        drive(1'b1, 100, 1'b0);
        i_valid = 1'b0;
        #2;
        i_rstb = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0);
        @(negedge i_clk);
        i_rstb = 1'b1;
        drive(1'b1, 16, 1'b0);
        expect_out("post_rst", 1, 4, 0);
        drive(1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/moving_average_win.md
MOVING_AVERAGE_WIN -- requirements
Module: moving_average_win

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 16, giving the signed sample width in bits (minimum 2).
REQ-002 The block SHALL have parameter LOG2_LEN, default 3, giving the window length N = 2**LOG2_LEN (range 0..8).
REQ-003 The block SHALL have parameter ROUND, default 0, selecting truncation (0, floor) or round-half-up (1).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port i_rstb, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_valid, input, 1 bit: i_data carries a sample this cycle.
REQ-007 The block SHALL have port i_data, input, signed DATA_WD bits: the input sample.
REQ-008 The block SHALL have port i_flush, input, 1 bit: synchronous window clear.
REQ-009 The block SHALL have port o_valid, input-driven output, 1 bit: o_data was updated this cycle.
REQ-010 The block SHALL have port o_data, output, signed DATA_WD bits: the window average.
REQ-011 The block SHALL have port o_full, output, 1 bit: N samples have been accepted since the last reset or flush.

Function
REQ-012 A sample SHALL be accepted on every rising edge with i_valid=1; there is no backpressure.
REQ-013 The running sum SHALL be signed, DATA_WD+LOG2_LEN bits wide, and on each accepted sample updated as sum + new - oldest.
REQ-014 While fewer than N samples have been accepted, oldest SHALL be treated as 0, so the missing history counts as zeros.
REQ-015 The history SHALL be a circular buffer of N entries with a write pointer that wraps from N-1 to 0.
REQ-016 With ROUND=0, o_data SHALL equal the updated sum arithmetically shifted right by LOG2_LEN.
REQ-017 With ROUND=1 and LOG2_LEN>0, o_data SHALL equal (sum + 2**(LOG2_LEN-1)) arithmetically shifted right by LOG2_LEN.
REQ-018 The result SHALL never overflow DATA_WD, and no saturation logic is permitted.
REQ-019 With LOG2_LEN=0, o_data SHALL equal the accepted sample.
REQ-020 o_valid SHALL pulse exactly one cycle after each accepted sample, and o_data SHALL update in that same cycle (latency 1).
REQ-021 When no sample is accepted, o_valid SHALL be 0 and o_data SHALL hold its last value.
REQ-022 The fill counter SHALL saturate at N.
REQ-023 o_full SHALL rise in the cycle o_valid reports the Nth sample and stay high until reset or flush.
REQ-024 A flush SHALL zero the sum, fill count and write pointer; o_data SHALL hold its value and o_full SHALL drop the next cycle.
REQ-025 If i_flush and i_valid are both high in a cycle, the flush SHALL apply first and that sample SHALL become the first sample of the new window, with o_valid=1 next cycle and o_data = sample/N per the rounding rule.
REQ-026 Buffer contents need not be cleared, because fill-count masking makes stale entries invisible.

Reset
REQ-027 While i_rstb=0, o_data SHALL be 0, o_valid 0 and o_full 0, and the sum, fill count and write pointer SHALL be 0.
REQ-028 Reset asserted mid-window SHALL discard all history, and the first sample after release SHALL average against zeros.
REQ-029 The buffer RAM SHALL have no reset.

Structure
REQ-030 Package moving_average_pkg SHALL hold the sample and sum typedefs parameterised via width localparams, and the function computing the shift and round.
REQ-031 The N-entry circular history SHALL be in one sub-module, ma_history_buf, with write-enable, pointer and read-old-data ports.
REQ-032 The top level SHALL hold the sum, fill counter, flags and output registers.

Verification (DATA_WD=16, LOG2_LEN=2 unless stated)
REQ-033 Ramp: i_data 4, 8, 12, 16, 20 on consecutive cycles SHALL give o_data 1, 3, 6, 10, 14, with o_full rising on the 10.
REQ-034 Rounding: constant -1 with ROUND=0 SHALL give -1; the same stimulus with ROUND=1 SHALL give 0 on the first output and -1 once full.
REQ-035 Extremes: four samples of 32767 SHALL give a final 32767, and four of -32768 SHALL give a final -32768, with no wrap.
REQ-036 Gaps: samples 8, gap of 3 idle cycles, 8 SHALL give o_valid only in the two output cycles, with o_data 2, held, then 4.
REQ-037 Flush: after 40, 40, 40, 40 (output 40), i_flush together with i_valid and 100 SHALL give next o_data 25 with o_full=0.
REQ-038 Reset: asserting i_rstb low mid-window SHALL clear all outputs immediately, and after release a sample of 16 SHALL give o_data 4.
